rr_stream_mux_2x1: RTL and testbench

//   Registered two-input stream multiplexer with round-robin arbitration.
//   - Sits upstream of the combinational 2:1 mux data path.
//   - Accepts words from sources A and B over valid/ready handshakes.
//   - Forwards one word per cycle through a single output register.
//   - Drives sel to identify the source of the word currently held (0=A, 1=B).

---
 rtl/rr_stream_mux_2x1.sv | 137 +++++++++++++
 tb/tb_rr_stream_mux_2x1.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_mux_2x1.sv
// rr_stream_mux_2x1
//   Registered two-input stream multiplexer with round-robin arbitration.
//   Words from sources A and B arrive over valid/ready handshakes, and one word
//   per cycle is forwarded through a single output register. sel identifies
//   the source of the held word.
//
//   Optional feature: define RR_COUNT_EN to add per-source accepted-transfer
//   counters (a_cnt, b_cnt). These counters wrap silently.
//
// Parameters
//   WIDTH      data width of a_data, b_data, out_data
//   CNT_WIDTH  width of the grant counters (used only with RR_COUNT_EN)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   a_valid    source A has a word
//   a_data     source A word
//   a_ready    A word accepted this cycle
//   b_valid    source B has a word
//   b_data     source B word
//   b_ready    B word accepted this cycle
//   out_valid  output register holds a word
//   out_data   held word
//   out_ready  consumer takes the word when out_valid & out_ready
//   sel        source of held word: 0=A, 1=B
//   a_cnt      accepted A transfers (RR_COUNT_EN only)
//   b_cnt      accepted B transfers (RR_COUNT_EN only)
module rr_stream_mux_2x1 #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel
`ifdef RR_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] a_cnt,
  output logic [CNT_WIDTH-1:0] b_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FULL_A = 2'd1,
    FULL_B = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last;      // source of the last accepted word: 0=A, 1=B
  logic   can_load;
  logic   grant_b;
  logic   load_a;
  logic   load_b;

  // Reject a degenerate counter width at elaboration time.
  if (CNT_WIDTH == 0) begin : g_cnt_width_chk
    $error("rr_stream_mux_2x1: CNT_WIDTH must be nonzero");
  end

  // Arbitration and next state. The register can take a new word when it is
  // empty or being drained in this same cycle. On a tie, the source that did
  // not win last time is granted.
  always_comb begin : p_next
    can_load  = (state == EMPTY) | out_ready;
    grant_b   = b_valid & (~a_valid | ~last);
    load_a    = can_load & a_valid & ~grant_b;
    load_b    = can_load & grant_b;
    state_nxt = state;
    if (load_a) begin
      state_nxt = FULL_A;
    end else if (load_b) begin
      state_nxt = FULL_B;
    end else if (can_load) begin
      state_nxt = EMPTY;
    end
  end

  assign a_ready   = load_a;
  assign b_ready   = load_b;
  assign out_valid = (state != EMPTY);

  // Output register occupancy.
  always_ff @(posedge clk or posedge rst) begin : p_state
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Data path. Data, sel and the round-robin pointer move only on an accepted
  // transfer. They hold through stalls and through draining to EMPTY.
  always_ff @(posedge clk or posedge rst) begin : p_data
    if (rst) begin
      out_data <= '0;
      sel      <= 1'b0;
      last     <= 1'b1;
    end else if (load_a) begin
      out_data <= a_data;
      sel      <= 1'b0;
      last     <= 1'b0;
    end else if (load_b) begin
      out_data <= b_data;
      sel      <= 1'b1;
      last     <= 1'b1;
    end
  end

`ifdef RR_COUNT_EN
  // Per-source accepted-transfer counters. They wrap on overflow.
  always_ff @(posedge clk or posedge rst) begin : p_cnt
    if (rst) begin
      a_cnt <= '0;
      b_cnt <= '0;
    end else begin
      if (load_a) begin
        a_cnt <= a_cnt + CNT_WIDTH'(1);
      end
      if (load_b) begin
        b_cnt <= b_cnt + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_rr_stream_mux_2x1.sv
// Testbench for rr_stream_mux_2x1. Directed stimulus pushes expected
// {sel, data} words into a scoreboard. A monitor pops one entry and compares
// it against the output on each cycle where the consumer takes a word.
module tb_rr_stream_mux_2x1;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  logic         clk;
  logic         rst;
  logic         a_valid;
  logic [W-1:0] a_data;
  logic         a_ready;
  logic         b_valid;
  logic [W-1:0] b_data;
  logic         b_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         sel;
`ifdef RR_COUNT_EN
  logic [CW-1:0] a_cnt;
  logic [CW-1:0] b_cnt;
`endif

  int checks;
  int failures;
  logic [W:0] exp_q[$];

  rr_stream_mux_2x1 #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .rst(rst),
    .a_valid(a_valid),
    .a_data(a_data),
    .a_ready(a_ready),
    .b_valid(b_valid),
    .b_data(b_data),
    .b_ready(b_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .sel(sel)
`ifdef RR_COUNT_EN
    ,
    .a_cnt(a_cnt),
    .b_cnt(b_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One stimulus cycle. Inputs are driven just after the edge. Readies and
  // out_valid are checked once the inputs settle. Expected accepted words go
  // to the scoreboard.
  task automatic cyc(input string tag, input logic av, input logic [W-1:0] ad,
                     input logic bv, input logic [W-1:0] bd, input logic ordy,
                     input logic eov, input logic ear, input logic ebr);
    @(posedge clk);
    #1;
    a_valid   = av;
    a_data    = ad;
    b_valid   = bv;
    b_data    = bd;
    out_ready = ordy;
    #2;
    chk({tag, ".out_valid"}, int'(out_valid), int'(eov));
    chk({tag, ".a_ready"}, int'(a_ready), int'(ear));
    chk({tag, ".b_ready"}, int'(b_ready), int'(ebr));
    if (ear) exp_q.push_back({1'b0, ad});
    if (ebr) exp_q.push_back({1'b1, bd});
  endtask

  // Scoreboard monitor: compares each word taken by the consumer.
  task automatic monitor();
    logic [W:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb.unexpected: got sel=%0d data=%0h expected no word", sel, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("sb.data", int'(out_data), int'(e[W-1:0]));
          chk("sb.sel", int'(sel), int'(e[W]));
        end
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic stimulus();
    logic [W-1:0] d0;
    // Values during the initial reset.
    #2;
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.out_data", int'(out_data), 0);
    chk("rst.sel", int'(sel), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // A only: accepted immediately and shown the next cycle.
    cyc("a_only", 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

    // B streaming back to back: one word per cycle with no bubbles.
    for (int i = 0; i < 4; i++) begin
      cyc("b_stream", 1'b0, 8'h00, 1'b1, W'(8'hC0 + i), 1'b1, 1'b1, 1'b0, 1'b1);
    end
    cyc("drain1", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("idle1", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Fill with B, then stall with both sources valid. After release, A wins.
    d0 = 8'hD0;
    cyc("fill_b", 1'b0, 8'h00, 1'b1, d0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc("stall", 1'b1, 8'hE0, 1'b1, 8'hD1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("stall.out_data", int'(out_data), int'(d0));
      chk("stall.sel", int'(sel), 1);
    end
    cyc("release", 1'b1, 8'hE0, 1'b1, 8'hD1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc("drain2", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("idle2", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while holding an A word.
    cyc("load_5a", 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    a_valid   = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("full_a.out_valid", int'(out_valid), 1);
    chk("full_a.out_data", int'(out_data), 8'h5A);
    rst = 1'b1;
    #1;
    chk("arst.out_valid", int'(out_valid), 0);
    chk("arst.out_data", int'(out_data), 0);
    chk("arst.sel", int'(sel), 0);
    exp_q.delete();
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Both valid after reset: strict alternation starting with A.
    cyc("rr0", 1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("rr1", 1'b1, 8'hA1, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("rr2", 1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc("rr3", 1'b1, 8'hA2, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("drain3", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("idle3", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef RR_COUNT_EN
    // 17 A transfers wrap a 4-bit counter back to 1.
    do_reset();
    #2;
    chk("cnt.rst_a", int'(a_cnt), 0);
    for (int i = 0; i < 17; i++) begin
      cyc("cnt_a", 1'b1, W'(i), 1'b0, 8'h00, 1'b1, (i != 0), 1'b1, 1'b0);
    end
    cyc("cnt_drain", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("cnt.a_wrap", int'(a_cnt), 1);
    chk("cnt.b", int'(b_cnt), 0);
    cyc("cnt_idle", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    @(posedge clk);
    #1;
    chk("sb.empty", exp_q.size(), 0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    a_valid   = 1'b0;
    a_data    = '0;
    b_valid   = 1'b0;
    b_data    = '0;
    out_ready = 1'b1;
    fork
      monitor();
      stimulus();
    join_any
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
